// File: rtl/ddr3_simple_ctrl_if.sv
// Request port of the simple DDR3 command initiator.
// The master side offers a request; the slave side accepts it when valid and ready.
interface ddr3_simple_ctrl_if #(
    parameter int BA_W  = 3,
    parameter int ROW_W = 13,
    parameter int COL_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [BA_W-1:0]  req_ba;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;

    modport master (
        output req_valid, req_we, req_ba, req_row, req_col,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_we, req_ba, req_row, req_col,
        output req_ready
    );
endinterface

// File: rtl/ddr3_simple_ctrl.sv
// Minimal DDR3 command initiator: init MRS/ZQ, single open row, refresh,
// and CWL/CL-aligned data-phase strobes for an external DQ datapath.
module ddr3_simple_ctrl #(
    parameter int MEM_BA_WIDTH  = 3,
    parameter int MEM_ROW_WIDTH = 13,
    parameter int MEM_COL_WIDTH = 10,
    parameter int MEM_CL        = 6,
    parameter int MEM_CWL       = 8,
    parameter int INIT_CYCLES   = 16,
    parameter int TMRD          = 4,
    parameter int TZQ           = 16,
    parameter int TRCD          = 3,
    parameter int TRP           = 3,
    parameter int TWR           = 6,
    parameter int TRFC          = 20,
    parameter int TREFI         = 780
) (
    input  logic                     ck,
    input  logic                     reset_n,
    ddr3_simple_ctrl_if.slave        req,
    output logic                     cke,
    output logic                     cs_n,
    output logic                     ras_n,
    output logic                     cas_n,
    output logic                     we_n,
    output logic [MEM_BA_WIDTH-1:0]  ba,
    output logic [MEM_ROW_WIDTH-1:0] a,
    output logic                     wr_phase,
    output logic                     rd_phase,
    output logic                     init_done
);
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_ZQC = 4'b0110;

    localparam int WR_BUSY = MEM_CWL + 4 + TWR;
    localparam int RD_BUSY = MEM_CL + 4;

    function automatic int max2(int x, int y);
        return (x > y) ? x : y;
    endfunction

    localparam int WMAX = max2(max2(max2(INIT_CYCLES, TMRD), max2(TZQ, TRCD)),
                               max2(max2(TRP, TRFC), max2(WR_BUSY, RD_BUSY)));
    localparam int CW  = $clog2(WMAX + 1);
    localparam int RCW = $clog2(TREFI + 1);
    localparam int WP  = MEM_CWL + 3;
    localparam int RP  = MEM_CL + 3;

    // A gap of T cycles between commands needs T-1 cycles spent in S_WAIT.
    function automatic logic [CW-1:0] wload(int t);
        return (t > 1) ? CW'(t - 1) : '0;
    endfunction

    typedef enum logic [3:0] {
        S_CKE, S_MRS, S_ZQ, S_DONE, S_IDLE, S_PRE,
        S_ACT, S_RW, S_RPRE, S_REF, S_WAIT
    } state_t;

    state_t                   state_q, state_d, ret_q, ret_d;
    logic [CW-1:0]            wait_q, wait_d;
    logic [1:0]               mr_q, mr_d;
    logic                     cke_q, cke_d;
    logic [3:0]               cmd_q, cmd_d;
    logic [MEM_BA_WIDTH-1:0]  ba_q, ba_d, obank_q, obank_d, lba_q, lba_d;
    logic [MEM_ROW_WIDTH-1:0] a_q, a_d, orow_q, orow_d, lrow_q, lrow_d;
    logic [MEM_COL_WIDTH-1:0] lcol_q, lcol_d;
    logic                     lwe_q, lwe_d;
    logic                     ready_q, ready_d, done_q, done_d;
    logic                     open_q, open_d, rpend_q, rpend_d;
    logic [RCW-1:0]           rcnt_q, rcnt_d;
    logic [WP-1:0]            wp_q, wp_d;
    logic [RP-1:0]            rp_q, rp_d;
    logic                     wrph_q, wrph_d, rdph_q, rdph_d;

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        wait_d  = wait_q;
        mr_d    = mr_q;
        cke_d   = cke_q;
        cmd_d   = C_NOP;
        ba_d    = ba_q;
        a_d     = a_q;
        obank_d = obank_q;
        orow_d  = orow_q;
        lba_d   = lba_q;
        lrow_d  = lrow_q;
        lcol_d  = lcol_q;
        lwe_d   = lwe_q;
        done_d  = done_q;
        open_d  = open_q;
        rpend_d = rpend_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            S_CKE: begin
                if (int'(wait_q) + 1 >= INIT_CYCLES) begin
                    cke_d   = 1'b1;
                    wait_d  = '0;
                    mr_d    = 2'd0;
                    state_d = S_MRS;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_MRS: begin
                cmd_d = C_MRS;
                a_d   = '0;
                unique case (mr_q)
                    2'd0: begin
                        ba_d     = MEM_BA_WIDTH'(2);
                        a_d[5:3] = 3'(MEM_CWL - 5);
                    end
                    2'd1: ba_d = MEM_BA_WIDTH'(3);
                    2'd2: ba_d = MEM_BA_WIDTH'(1);
                    2'd3: begin
                        ba_d     = '0;
                        a_d[1:0] = 2'b01;
                        a_d[6:4] = 3'(MEM_CL - 4);
                        a_d[8]   = 1'b1;
                    end
                endcase
                mr_d    = mr_q + 1'b1;
                wait_d  = wload(TMRD);
                ret_d   = (mr_q == 2'd3) ? S_ZQ : S_MRS;
                state_d = S_WAIT;
            end
            S_ZQ: begin
                cmd_d   = C_ZQC;
                ba_d    = '0;
                a_d     = '0;
                a_d[10] = 1'b1;
                wait_d  = wload(TZQ);
                ret_d   = S_DONE;
                state_d = S_WAIT;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (rpend_q) begin
                    state_d = open_q ? S_RPRE : S_REF;
                end else if (req.req_valid && ready_q) begin
                    lwe_d  = req.req_we;
                    lba_d  = req.req_ba;
                    lrow_d = req.req_row;
                    lcol_d = req.req_col;
                    if (open_q && req.req_ba == obank_q && req.req_row == orow_q)
                        state_d = S_RW;
                    else if (open_q)
                        state_d = S_PRE;
                    else
                        state_d = S_ACT;
                end
            end
            S_PRE: begin
                cmd_d   = C_PRE;
                ba_d    = obank_q;
                a_d     = '0;
                open_d  = 1'b0;
                wait_d  = wload(TRP);
                ret_d   = S_ACT;
                state_d = S_WAIT;
            end
            S_ACT: begin
                cmd_d   = C_ACT;
                ba_d    = lba_q;
                a_d     = lrow_q;
                obank_d = lba_q;
                orow_d  = lrow_q;
                open_d  = 1'b1;
                wait_d  = wload(TRCD);
                ret_d   = S_RW;
                state_d = S_WAIT;
            end
            S_RW: begin
                cmd_d                   = lwe_q ? C_WR : C_RD;
                ba_d                    = lba_q;
                a_d                     = '0;
                a_d[MEM_COL_WIDTH-1:0]  = lcol_q;
                a_d[10]                 = 1'b0;
                a_d[12]                 = 1'b1;
                wait_d  = lwe_q ? wload(WR_BUSY) : wload(RD_BUSY);
                ret_d   = S_IDLE;
                state_d = S_WAIT;
            end
            S_RPRE: begin
                cmd_d   = C_PRE;
                ba_d    = '0;
                a_d     = '0;
                a_d[10] = 1'b1;
                open_d  = 1'b0;
                wait_d  = wload(TRP);
                ret_d   = S_REF;
                state_d = S_WAIT;
            end
            S_REF: begin
                cmd_d   = C_REF;
                open_d  = 1'b0;
                rpend_d = 1'b0;
                wait_d  = wload(TRFC);
                ret_d   = S_IDLE;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q <= CW'(1)) state_d = ret_q;
                else wait_d = wait_q - 1'b1;
            end
            default: state_d = S_CKE;
        endcase
        // A fresh expiry wins over the clear done when REF issues.
        if (done_q) begin
            if (rcnt_q == RCW'(TREFI - 1)) begin
                rcnt_d  = '0;
                rpend_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
        ready_d = (state_d == S_IDLE) && done_d && !rpend_d;
        wp_d    = {wp_q[WP-2:0], cmd_d == C_WR};
        rp_d    = {rp_q[RP-2:0], cmd_d == C_RD};
        wrph_d  = |wp_q[WP-1:WP-4];
        rdph_d  = |rp_q[RP-1:RP-4];
    end

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_CKE;
            ret_q   <= S_CKE;
            wait_q  <= '0;
            mr_q    <= 2'd0;
            cke_q   <= 1'b0;
            cmd_q   <= C_NOP;
            ba_q    <= '0;
            a_q     <= '0;
            obank_q <= '0;
            orow_q  <= '0;
            lba_q   <= '0;
            lrow_q  <= '0;
            lcol_q  <= '0;
            lwe_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            open_q  <= 1'b0;
            rpend_q <= 1'b0;
            rcnt_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            wrph_q  <= 1'b0;
            rdph_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            wait_q  <= wait_d;
            mr_q    <= mr_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            a_q     <= a_d;
            obank_q <= obank_d;
            orow_q  <= orow_d;
            lba_q   <= lba_d;
            lrow_q  <= lrow_d;
            lcol_q  <= lcol_d;
            lwe_q   <= lwe_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            open_q  <= open_d;
            rpend_q <= rpend_d;
            rcnt_q  <= rcnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            wrph_q  <= wrph_d;
            rdph_q  <= rdph_d;
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign cke           = cke_q;
    assign ba            = ba_q;
    assign a             = a_q;
    assign req.req_ready = ready_q;
    assign wr_phase      = wrph_q;
    assign rd_phase      = rdph_q;
    assign init_done     = done_q;
endmodule

// File: tb/tb_ddr3_simple_ctrl.sv
// Directed bench for ddr3_simple_ctrl: init sequence, hit/miss accesses,
// refresh under a held request, and reset in the middle of a write burst.
module tb_ddr3_simple_ctrl;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;
    localparam logic [3:0] ZQC = 4'b0110;

    logic        ck = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke, cs_n, ras_n, cas_n, we_n;
    logic [2:0]  ba;
    logic [12:0] a;
    logic        wr_phase, rd_phase, init_done;
    logic [3:0]  cmd;
    int          cyc = 0;
    int          vecs = 0;
    int          misses = 0;

    ddr3_simple_ctrl_if #(.BA_W(3), .ROW_W(13), .COL_W(10)) rq ();

    ddr3_simple_ctrl dut (
        .ck        (ck),
        .reset_n   (reset_n),
        .req       (rq),
        .cke       (cke),
        .cs_n      (cs_n),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .ba        (ba),
        .a         (a),
        .wr_phase  (wr_phase),
        .rd_phase  (rd_phase),
        .init_done (init_done)
    );

    assign cmd = {cs_n, ras_n, cas_n, we_n};

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            misses++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cmd(input int budget, output logic [3:0] c,
                            output int at);
        c  = NOP;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge ck);
            if (cmd !== NOP) begin
                c  = cmd;
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("cmd_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic we, input logic [2:0] b,
                        input logic [12:0] row, input logic [9:0] col,
                        output int acc);
        @(negedge ck);
        rq.req_valid = 1'b1;
        rq.req_we    = we;
        rq.req_ba    = b;
        rq.req_row   = row;
        rq.req_col   = col;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            if (rq.req_ready) begin
                acc = cyc + 1;
                @(negedge ck);
                rq.req_valid = 1'b0;
                break;
            end
            @(negedge ck);
        end
        if (acc < 0) begin
            chk("accept_timeout", 32'd1, 32'd0);
            rq.req_valid = 1'b0;
        end
    endtask

    task automatic watch(input bit sel_wr, input int n, output int first,
                         output int cnt);
        logic ph;
        first = -1;
        cnt   = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge ck);
            ph = sel_wr ? wr_phase : rd_phase;
            if (ph) begin
                if (first < 0) first = cyc;
                cnt++;
            end
        end
    endtask

    initial begin
        logic [3:0]  c;
        logic [2:0]  mr_ba [4];
        logic [12:0] mr_a  [4];
        int t0, tc, at, prev, acc, tw, first, cnt, ph_hits;
        logic seen;

        mr_ba = '{3'd2, 3'd3, 3'd1, 3'd0};
        mr_a  = '{13'h0018, 13'h0000, 13'h0000, 13'h0121};
        rq.req_valid = 1'b0;
        rq.req_we    = 1'b0;
        rq.req_ba    = '0;
        rq.req_row   = '0;
        rq.req_col   = '0;

        repeat (3) @(negedge ck);
        chk("rst_cke", cke, 0);
        chk("rst_cmd", cmd, NOP);
        chk("rst_ready", rq.req_ready, 0);
        chk("rst_done", init_done, 0);
        chk("rst_phase", {wr_phase, rd_phase}, 0);
        chk("rst_ba_a", {ba, a}, 0);

        reset_n = 1'b1;
        t0 = cyc;
        tc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge ck);
            if (cke) begin
                tc = cyc;
                break;
            end
        end
        chk("cke_low_cycles", tc - t0, 16);

        prev = 0;
        for (int k = 0; k < 4; k++) begin
            next_cmd(10, c, at);
            chk("mrs_cmd", c, MRS);
            chk("mrs_ba", ba, mr_ba[k]);
            chk("mrs_a", a, mr_a[k]);
            if (k > 0) chk("tmrd_gap", at - prev, 4);
            prev = at;
        end
        next_cmd(10, c, at);
        chk("zqc_cmd", c, ZQC);
        chk("zqc_a", a, 13'h0400);
        chk("zqc_gap", at - prev, 4);
        prev = at;
        tc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge ck);
            if (init_done) begin
                tc = cyc;
                break;
            end
        end
        chk("tzq_gap", tc - prev, 16);
        chk("idle_ready", rq.req_ready, 1);

        send(1'b1, 3'd2, 13'h0123, 10'h008, acc);
        next_cmd(10, c, at);
        chk("wr_act_cmd", c, ACT);
        chk("wr_act_ba_a", {ba, a}, {3'd2, 13'h0123});
        prev = at;
        next_cmd(10, c, tw);
        chk("wr_cmd", c, WR);
        chk("wr_ba_a", {ba, a}, {3'd2, 13'h1008});
        chk("trcd_gap", tw - prev, 3);
        watch(1'b1, 14, first, cnt);
        chk("wr_phase_start", first - tw, 8);
        chk("wr_phase_len", cnt, 4);

        send(1'b0, 3'd2, 13'h0123, 10'h008, acc);
        next_cmd(10, c, at);
        chk("hit_rd_cmd", c, RD);
        chk("hit_rd_ba_a", {ba, a}, {3'd2, 13'h1008});
        chk("hit_rd_latency", at - acc, 1);
        tw = at;
        watch(1'b0, 12, first, cnt);
        chk("rd_phase_start", first - tw, 6);
        chk("rd_phase_len", cnt, 4);

        send(1'b0, 3'd2, 13'h0200, 10'h010, acc);
        next_cmd(10, c, at);
        chk("miss_pre_cmd", c, PRE);
        chk("miss_pre_ba", ba, 3'd2);
        chk("miss_pre_a10", a[10], 0);
        prev = at;
        next_cmd(10, c, at);
        chk("miss_act_cmd", c, ACT);
        chk("miss_act_a", a, 13'h0200);
        chk("trp_gap", at - prev, 3);
        prev = at;
        next_cmd(10, c, at);
        chk("miss_rd_cmd", c, RD);
        chk("miss_rd_a", a, 13'h1010);
        chk("miss_trcd_gap", at - prev, 3);

        @(negedge ck);
        rq.req_valid = 1'b1;
        rq.req_we    = 1'b0;
        rq.req_ba    = 3'd2;
        rq.req_row   = 13'h0200;
        rq.req_col   = 10'h000;
        c = RD;
        for (int i = 0; i < 200 && c == RD; i++) next_cmd(30, c, at);
        chk("ref_pre_cmd", c, PRE);
        chk("ref_pre_a10", a[10], 1);
        prev = at;
        next_cmd(10, c, at);
        chk("ref_cmd", c, REF);
        chk("ref_trp_gap", at - prev, 3);
        prev = at;
        next_cmd(40, c, at);
        rq.req_valid = 1'b0;
        chk("post_ref_act", c, ACT);
        chk("post_ref_act_a", a, 13'h0200);
        chk("trfc_respected", (at - prev) >= 20, 1);
        next_cmd(10, c, at);
        chk("post_ref_rd", c, RD);

        send(1'b1, 3'd2, 13'h0200, 10'h018, acc);
        next_cmd(10, c, tw);
        chk("burst_wr_cmd", c, WR);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge ck);
            if (wr_phase) begin
                seen = 1'b1;
                break;
            end
        end
        chk("burst_wr_phase_seen", seen, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_cke", cke, 0);
        chk("midrst_cmd", cmd, NOP);
        chk("midrst_wr_phase", wr_phase, 0);
        chk("midrst_done_ready", {init_done, rq.req_ready}, 0);
        chk("midrst_ba_a", {ba, a}, 0);
        @(negedge ck);
        reset_n = 1'b1;
        t0 = cyc;
        tc = -1;
        ph_hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge ck);
            if (wr_phase || rd_phase) ph_hits++;
            if (cke) begin
                tc = cyc;
                break;
            end
        end
        chk("reinit_cke_low", tc - t0, 16);
        chk("reinit_no_phase", ph_hits, 0);
        next_cmd(10, c, at);
        chk("reinit_mr2", {c, ba}, {MRS, 3'd2});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
        $finish;
    end
endmodule
